// File: rtl/plot_pkg.sv
// Shared types and helpers for the plot sink: screen geometry, FSM states,
// the FIFO entry layout and the pixel-address arithmetic.
package plot_pkg;

    localparam int DEF_SCR_W = 160;
    localparam int DEF_SCR_H = 120;
    localparam int ADDR_W    = 15;
    localparam int COLOUR_W  = 3;
    localparam int COUNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } plot_entry_t;

    // Row-major address in 15-bit arithmetic; a constant width of 160 reduces
    // to (y<<7)+(y<<5)+x.
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [7:0]  x,
        input logic [6:0]  y,
        input int unsigned w
    );
        return ADDR_W'(y) * ADDR_W'(w) + ADDR_W'(x);
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO for plot entries; exposes the head and the entry
// behind it so the drain side can present back-to-back writes without a bubble.
module plot_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [17:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output entry_t                 second,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only lands when a pop frees the slot on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign second  = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/plot_sink.sv
// Receiving end of the drawing-engine plot bus: bounds-checks and buffers plots,
// drains them to a ready-handshaked framebuffer port, and runs a full-screen clear.
module plot_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int SCR_W      = 160,
    parameter int SCR_H      = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_start,
    input  logic [2:0]  clear_colour,
    output logic        clear_done,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_wdata,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic        overflow,
    output logic [15:0] plot_count,
    output logic [15:0] drop_count
);

    import plot_pkg::*;

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [14:0] LAST_ADDR = 15'(SCR_W * SCR_H - 1);

    state_t        state;
    plot_entry_t   push_entry;
    plot_entry_t   head;
    plot_entry_t   second;
    plot_entry_t   follow;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          in_range;
    logic          push;
    logic          pop;
    logic          more_after_pop;

    assign in_range   = (int'(vga_x) < SCR_W) && (int'(vga_y) < SCR_H);
    assign push       = vga_plot && in_range;
    assign pop        = (state == DRAIN) && fb_we && fb_ready;
    assign push_entry = '{addr: pixel_addr(vga_x, vga_y, SCR_W), colour: vga_colour};

    // After a drain handshake the next write is either the entry behind the head
    // or, when the head was the only one, the plot arriving on that same edge.
    assign more_after_pop = (fifo_count > CW'(1)) || push;
    assign follow         = (fifo_count > CW'(1)) ? second : push_entry;

    plot_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (plot_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .second    (second),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state    <= CLEAR;
                        fb_we    <= 1'b1;
                        fb_addr  <= '0;
                        fb_wdata <= clear_colour;
                    end else if (!fifo_empty) begin
                        state    <= DRAIN;
                        fb_we    <= 1'b1;
                        fb_addr  <= head.addr;
                        fb_wdata <= head.colour;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        if (more_after_pop) begin
                            fb_addr  <= follow.addr;
                            fb_wdata <= follow.colour;
                        end else begin
                            fb_we <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                // fb_addr doubles as the clear counter and fb_wdata holds the latched colour.
                CLEAR: begin
                    if (fb_ready) begin
                        if (fb_addr == LAST_ADDR) begin
                            fb_we      <= 1'b0;
                            clear_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            fb_addr <= fb_addr + 15'd1;
                        end
                    end
                end
                DONE: begin
                    if (!clear_start) begin
                        clear_done <= 1'b0;
                        if (!fifo_empty) begin
                            state    <= DRAIN;
                            fb_we    <= 1'b1;
                            fb_addr  <= head.addr;
                            fb_wdata <= head.colour;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    fb_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plot_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop) begin
                plot_count <= sat_inc(plot_count);
            end
            if (vga_plot && !in_range) begin
                drop_count <= sat_inc(drop_count);
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_plot_sink.sv
// Directed and randomized checks of plot_sink against a queue-based model of
// the plots that should reach the framebuffer.
module tb_plot_sink;

    localparam int SCR_W      = 160;
    localparam int SCR_H      = 120;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        clear_start = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic        clear_done;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        fb_we;
    logic        fb_ready = 1'b0;
    logic        overflow;
    logic [15:0] plot_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          m_plot_count = 0;
    int          m_drop_count = 0;
    logic        m_overflow = 1'b0;
    logic        stall_mode = 1'b0;
    int          stalled_cnt = 0;

    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [14:0] prev_addr = '0;
    logic [2:0]  prev_data = '0;

    plot_sink #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SCR_W      (SCR_W),
        .SCR_H      (SCR_H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .fb_we        (fb_we),
        .fb_ready     (fb_ready),
        .overflow     (overflow),
        .plot_count   (plot_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    // Inputs change just after rising edges, so a falling-edge sample shows what the next edge will see.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!fb_we || fb_addr !== prev_addr || fb_wdata !== prev_data)) begin
                stall_viol++;
            end
            prev_stall = fb_we && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_wdata;
            if (fb_we && fb_ready) begin
                got_q.push_back({fb_addr, fb_wdata});
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic modelPlot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        if (int'(x) < SCR_W && int'(y) < SCR_H) begin
            if (stall_mode && stalled_cnt >= FIFO_DEPTH) begin
                m_overflow = 1'b1;
            end else begin
                exp_q.push_back({15'(int'(y) * SCR_W + int'(x)), c});
                if (m_plot_count < 65535) m_plot_count++;
                if (stall_mode) stalled_cnt++;
            end
        end else begin
            if (m_drop_count < 65535) m_drop_count++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        vga_x      = x;
        vga_y      = y;
        vga_colour = c;
        vga_plot   = 1'b1;
        modelPlot(x, y, c);
        tick();
        vga_plot   = 1'b0;
    endtask

    task automatic drainCheck(input string tag);
        int n;
        int budget;
        int bad;
        n = exp_q.size();
        budget = 0;
        while (got_q.size() < n && budget < 500) begin
            tick();
            budget++;
        end
        repeat (3) tick();
        checkOutput({tag, " write count"}, 32'(got_q.size()), 32'(n));
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        end
        checkOutput({tag, " write data"}, 32'(bad), 32'd0);
        checkOutput({tag, " plot_count"}, 32'(plot_count), 32'(m_plot_count));
        checkOutput({tag, " drop_count"}, 32'(drop_count), 32'(m_drop_count));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(m_overflow));
        checkOutput({tag, " fb_we idle"}, 32'(fb_we), 32'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        int bad;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset fb_we", 32'(fb_we), 32'd0);
        checkOutput("reset fb_addr", 32'(fb_addr), 32'd0);
        checkOutput("reset fb_wdata", 32'(fb_wdata), 32'd0);
        checkOutput("reset clear_done", 32'(clear_done), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset plot_count", 32'(plot_count), 32'd0);
        checkOutput("reset drop_count", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single plot and its latency.
        fb_ready = 1'b1;
        applyStimulus(8'd80, 7'd60, 3'b010);
        checkOutput("t1 fb_we after k", 32'(fb_we), 32'd0);
        tick();
        checkOutput("t1 fb_we after k+1", 32'(fb_we), 32'd1);
        checkOutput("t1 fb_addr", 32'(fb_addr), 32'd9680);
        checkOutput("t1 fb_wdata", 32'(fb_wdata), 32'd2);
        tick();
        checkOutput("t1 fb_we after k+2", 32'(fb_we), 32'd0);
        drainCheck("t1");

        // Bounds: two out of range, one at the far corner.
        applyStimulus(8'd160, 7'd0, 3'b001);
        applyStimulus(8'd0, 7'd120, 3'b101);
        applyStimulus(8'd159, 7'd119, 3'b110);
        drainCheck("t2");

        // Random back-to-back plots with fb_ready held high.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
                          3'($urandom_range(0, 7)));
        end
        drainCheck("rand_burst");

        // Short random bursts against a randomly stalling framebuffer.
        for (int b = 0; b < 5; b++) begin
            int n;
            int budget;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                fb_ready = 1'($urandom_range(0, 1));
                applyStimulus(8'($urandom_range(0, 200)), 7'($urandom_range(0, 127)),
                              3'($urandom_range(0, 7)));
            end
            budget = 0;
            while (got_q.size() < exp_q.size() && budget < 200) begin
                fb_ready = 1'($urandom_range(0, 1));
                tick();
                budget++;
            end
        end
        fb_ready = 1'b1;
        drainCheck("rand_stall");

        // Backpressure: ten plots into a stalled eight-entry FIFO.
        fb_ready    = 1'b0;
        stall_mode  = 1'b1;
        stalled_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'(i + 20), 7'd50, 3'(i));
            if (i == 7) checkOutput("t3 overflow before 9th", 32'(overflow), 32'd0);
            if (i == 8) checkOutput("t3 overflow after 9th", 32'(overflow), 32'd1);
        end
        repeat (5) tick();
        checkOutput("t3 stalled fb_we", 32'(fb_we), 32'd1);
        checkOutput("t3 stalled fb_addr", 32'(fb_addr), 32'd8020);
        stall_mode = 1'b0;
        fb_ready   = 1'b1;
        drainCheck("t3");
        checkOutput("t3 stability", 32'(stall_viol), 32'd0);

        // Full-screen clear at full rate; colour is changed after acceptance.
        clear_colour = 3'b111;
        clear_start  = 1'b1;
        tick();
        clear_colour = 3'b001;
        cyc = 0;
        while (clear_done !== 1'b1 && cyc < 20100) begin
            tick();
            cyc++;
        end
        checkOutput("t4 clear_done", 32'(clear_done), 32'd1);
        checkOutput("t4 write count", 32'(got_q.size()), 32'(SCR_W * SCR_H));
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== {15'(i), 3'b111}) bad++;
        end
        checkOutput("t4 write data", 32'(bad), 32'd0);
        checkOutput("t4 plot_count", 32'(plot_count), 32'(m_plot_count));
        tick();
        checkOutput("t4 clear_done held", 32'(clear_done), 32'd1);
        checkOutput("t4 fb_we in done", 32'(fb_we), 32'd0);
        clear_start = 1'b0;
        tick();
        checkOutput("t4 clear_done released", 32'(clear_done), 32'd0);
        got_q.delete();

        // Clear with fb_ready toggling and a plot arriving mid-clear.
        clear_colour = 3'b101;
        clear_start  = 1'b1;
        fb_ready     = 1'b0;
        cyc = 0;
        while (clear_done !== 1'b1 && cyc < 40500) begin
            fb_ready = ~fb_ready;
            if (cyc == 100) applyStimulus(8'd40, 7'd40, 3'b011);
            else tick();
            cyc++;
        end
        checkOutput("t5 clear_done", 32'(clear_done), 32'd1);
        checkOutput("t5 clear write count", 32'(got_q.size()), 32'(SCR_W * SCR_H));
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== {15'(i), 3'b101}) bad++;
        end
        checkOutput("t5 clear write data", 32'(bad), 32'd0);
        got_q.delete();
        clear_start = 1'b0;
        fb_ready    = ~fb_ready;
        tick();
        checkOutput("t5 clear_done released", 32'(clear_done), 32'd0);
        fb_ready = 1'b1;
        drainCheck("t5");
        checkOutput("t5 stability", 32'(stall_viol), 32'd0);

        // Reset in the middle of a clear.
        clear_colour = 3'b110;
        clear_start  = 1'b1;
        cyc = 0;
        while (!(fb_we === 1'b1 && fb_addr === 15'd5000) && cyc < 6000) begin
            tick();
            cyc++;
        end
        checkOutput("t6 reached addr", 32'(fb_addr), 32'd5000);
        rst_n = 1'b0;
        #2;
        checkOutput("t6 reset fb_we", 32'(fb_we), 32'd0);
        checkOutput("t6 reset fb_addr", 32'(fb_addr), 32'd0);
        checkOutput("t6 reset fb_wdata", 32'(fb_wdata), 32'd0);
        checkOutput("t6 reset clear_done", 32'(clear_done), 32'd0);
        checkOutput("t6 reset overflow", 32'(overflow), 32'd0);
        checkOutput("t6 reset plot_count", 32'(plot_count), 32'd0);
        checkOutput("t6 reset drop_count", 32'(drop_count), 32'd0);
        clear_start  = 1'b0;
        m_plot_count = 0;
        m_drop_count = 0;
        m_overflow   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        tick();
        tick();
        checkOutput("t6 idle fb_we", 32'(fb_we), 32'd0);
        applyStimulus(8'($urandom_range(0, SCR_W - 1)), 7'($urandom_range(0, SCR_H - 1)),
                      3'($urandom_range(0, 7)));
        drainCheck("t6");
        checkOutput("final stability", 32'(stall_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the plot interface that circle and the other drawing engines drive: x, y, colour and a one-cycle plot strobe.
- There is no backpressure on that interface, so this block bounds-checks each plot, buffers it in a small FIFO and drains it into a single-port framebuffer write interface that does have a ready handshake.
- Also runs a full-screen clear engine and exposes status counters.
- Sits between the drawing engines and the framebuffer RAM, as a replacement for feeding vga_adapter directly.

Parameters:
- FIFO_DEPTH, 8, plot FIFO entries; power of two, at least 2.
- SCR_W, 160, screen width in pixels.
- SCR_H, 120, screen height in pixels.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  plot strobe; one plot per cycle high.
- clear_start  in  1  level request to fill the screen with clear_colour.
- clear_colour  in  3  fill colour, sampled on the accepting edge.
- clear_done  out  1  clear finished; held until clear_start is deasserted.
- fb_addr  out  15  framebuffer address, y*SCR_W+x.
- fb_wdata  out  3  framebuffer write colour.
- fb_we  out  1  write valid.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- overflow  out  1  sticky: an in-range plot was lost because the FIFO was full.
- plot_count  out  16  in-range plots written to the framebuffer; saturates at 16'hFFFF.
- drop_count  out  16  out-of-range plots discarded; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0: fb_we, fb_addr, fb_wdata, clear_done, overflow, both counters.
  - FIFO emptied; state IDLE.
  - Reset mid-clear or mid-drain aborts the operation; pending entries are lost.
- Input acceptance, every edge with vga_plot=1:
  - vga_x>=SCR_W or vga_y>=SCR_H: drop; drop_count+1; no FIFO write; overflow not affected.
  - Otherwise push {addr=vga_y*SCR_W+vga_x, colour}.
  - Address multiply is done at push in 15-bit unsigned arithmetic: y*160 = (y<<7)+(y<<5).
- FIFO rules:
  - Push when full with no pop that edge: entry discarded; overflow set to 1 and stays set until reset.
  - Push and pop on the same edge while full: both occur; no overflow.
  - Pop only on a fb handshake edge (fb_we && fb_ready) in DRAIN.
- Write handshake:
  - fb_we, fb_addr and fb_wdata are registered.
  - Once fb_we is high, fb_addr and fb_wdata hold stable until an edge with fb_ready=1.
  - Latency: a plot sampled at edge k on an empty FIFO in IDLE gives fb_we=1 after edge k+1.
  - With fb_ready tied high: one write per cycle sustained; back-to-back strobes never overflow.
- State machine (IDLE, DRAIN, CLEAR, DONE):
  - IDLE: clear_start=1 → CLEAR, counter=0, colour latched. Else FIFO non-empty → DRAIN.
  - DRAIN: present the head entry. After a handshake: FIFO now empty → IDLE; else present the next entry in the following cycle with no bubble.
  - clear_start only takes effect from IDLE, so a pending clear waits until the FIFO empties.
  - CLEAR:
    - fb_we=1, addr=counter, wdata=latched colour; counter+1 on each handshake.
    - Write SCR_W*SCR_H-1 (19199) is the final one; after its handshake → DONE with clear_done=1.
    - Plots arriving during CLEAR are still bounds-checked and pushed; they may overflow.
    - Clear writes do not increment plot_count.
  - DONE: clear_done=1. When clear_start=0: clear_done=0, then → IDLE, or → DRAIN if the FIFO is non-empty.
- plot_count increments on each DRAIN handshake.
- Both counters saturate rather than wrap.

Decomposition:
- Package plot_pkg: SCR_W/SCR_H constants, state enum, and a plot-entry struct {logic [14:0] addr; logic [2:0] colour;}.
- One sub-module, plot_fifo:
  - Synchronous FIFO parameterised on depth and entry type.
  - push, pop, full, empty; simultaneous push/pop when full is allowed.

Test Plan:
1. Single plot: reset, fb_ready=1, plot (80,60,3'b010) → after edge k+1, fb_we=1, fb_addr=9680, fb_wdata=3'b010 for one cycle; plot_count=1.
2. Bounds: plots (160,0), (0,120), (159,119) → drop_count=2; one write with fb_addr=19199; overflow=0.
3. Backpressure: fb_ready=0, plot 10 consecutive in-range pixels → overflow=1 after the 9th. Raise fb_ready → exactly 8 writes, addresses in plot order, fields stable while stalled.
4. Clear: clear_start=1, clear_colour=3'b111, fb_ready=1 → 19200 writes, addresses 0..19199, then clear_done=1; drop clear_start → clear_done=0 next cycle.
5. Clear with stalls and plots: toggle fb_ready every cycle; plot (40,40) mid-clear → the clear completes first, then one write to addr 6440; plot_count=1.
6. Reset mid-clear: assert rst_n=0 at clear address 5000 → all outputs 0 immediately; after release the block is in IDLE and a new plot drains normally.
